// File: rtl/mux3_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux3_arb_pkg
// Shared definitions for the three-requester round-robin arbiter:
//   - arbState_e  : arbiter FSM encoding (IDLE, GRANT)
//   - SEL_IN00 / SEL_IN01 / SEL_IN10 : mux select codes for the datapath
//   - oneHotToSel : maps a one-hot grant vector to its mux select code
//   - pickWinner  : round-robin search starting at a priority pointer
//   - nextPtr     : increments a requester index modulo 3
// ---------------------------------------------------------------------------
package mux3_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbState_e;

    localparam logic [1:0] SEL_IN00 = 2'b00;
    localparam logic [1:0] SEL_IN01 = 2'b01;
    localparam logic [1:0] SEL_IN10 = 2'b10;

    // The select code doubles as the grantee index, so the arbiter reuses
    // sel wherever it needs "which requester holds the grant".
    function automatic logic [1:0] oneHotToSel(input logic [2:0] oneHot);
        logic [1:0] selCode;
        case (oneHot)
            3'b010:  selCode = SEL_IN01;
            3'b100:  selCode = SEL_IN10;
            default: selCode = SEL_IN00;
        endcase
        return selCode;
    endfunction

    function automatic logic [1:0] nextPtr(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Walks the offsets from farthest to nearest so that the last hit, which
    // wins, is the requester closest to (or at) the pointer.
    function automatic logic [2:0] pickWinner(input logic [2:0] reqVec,
                                              input logic [1:0] ptr);
        logic [2:0] winner;
        logic [1:0] idx;
        winner = 3'b000;
        idx    = ptr;
        for (int off = 0; off < 2; off++) begin
            idx = nextPtr(idx);
        end
        for (int off = 0; off < 3; off++) begin
            if (reqVec[idx]) begin
                winner = 3'b000;
                winner[idx] = 1'b1;
            end
            idx = (idx == 2'd0) ? 2'd2 : idx - 2'd1;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mux3_arbiter_mux.sv
// ---------------------------------------------------------------------------
// Mux_3_1
// The existing 32-bit (WIDTH-bit) 3:1 datapath mux shared by the arbiter.
// Ports:
//   in00, in01, in10 : data inputs selected by sel = 00 / 01 / 10
//   sel              : select code; 2'b11 yields all zeros
//   out              : selected word
// ---------------------------------------------------------------------------
module Mux_3_1
    import mux3_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in00,
    input  logic [WIDTH-1:0] in01,
    input  logic [WIDTH-1:0] in10,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    // Pure combinational select; the unused code drives zero rather than
    // leaving the output undefined.
    always_comb begin
        case (sel)
            SEL_IN00: out = in00;
            SEL_IN01: out = in01;
            SEL_IN10: out = in10;
            default:  out = '0;
        endcase
    end

endmodule

// File: rtl/mux3_arbiter.sv
// ---------------------------------------------------------------------------
// mux3_arbiter
// Round-robin arbiter granting one of three requesters the shared 3:1 mux
// and presenting the selected word to a single valid/ready consumer.
// Optional feature macro: ARB_LOCK_EN (adds the lock port and a beat counter
// that lets a locked grantee keep the grant for up to MAX_LOCK beats).
// Ports:
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   req [2:0]        : per-requester valid word
//   in00/in01/in10   : requester data words
//   lock [2:0]       : per-requester hold-grant flag (ARB_LOCK_EN only)
//   out_ready        : consumer accepts out_data this cycle
//   out_valid        : out_data holds the grantee's word
//   out_data         : mux output for sel
//   sel [1:0]        : registered mux select
//   gnt [2:0]        : registered one-hot grant, 000 when idle
//   ack [2:0]        : one-hot accept pulse to the grantee
// ---------------------------------------------------------------------------
module mux3_arbiter
    import mux3_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] in00,
    input  logic [WIDTH-1:0] in01,
    input  logic [WIDTH-1:0] in10,
`ifdef ARB_LOCK_EN
    input  logic [2:0]       lock,
`endif
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic [2:0]       gnt,
    output logic [2:0]       ack
);

    if (MAX_LOCK < 1 || MAX_LOCK > 15) begin : gBadMaxLock
        $error("mux3_arbiter: MAX_LOCK must be within 1..15");
    end

    arbState_e  state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic       grantedReq;
    logic       accept;
    logic       lockHold;
    logic [2:0] maskedReq;
    logic [2:0] idleWinner;
    logic [2:0] rotWinner;
`ifdef ARB_LOCK_EN
    // The counter holds beats already accepted in the current grant, so the
    // accept that would make it MAX_LOCK is the one that releases the grant.
    localparam logic [3:0] LockLast = 4'(MAX_LOCK - 1);
    logic [3:0] lockCnt_q, lockCnt_d;
`endif

    Mux_3_1 #(.WIDTH(WIDTH)) uMux (
        .in00 (in00),
        .in01 (in01),
        .in10 (in10),
        .sel  (sel_q),
        .out  (out_data)
    );

    // Handshake outputs: valid tracks the grantee's request live, and ack is
    // a same-cycle function of out_ready with no register in between.
    always_comb begin
        grantedReq = |(req & gnt_q);
        out_valid  = (state_q == GRANT) && grantedReq;
        accept     = out_valid && out_ready;
        ack        = accept ? gnt_q : 3'b000;
        gnt        = gnt_q;
        sel        = sel_q;
    end

    // Next-state logic. On accept the current grantee is masked out and the
    // search restarts just after it, which is what produces the rotation and
    // forbids the same requester winning twice in a row.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        lockHold   = 1'b0;
        maskedReq  = req & ~gnt_q;
        idleWinner = pickWinner(req, ptr_q);
        rotWinner  = pickWinner(maskedReq, nextPtr(sel_q));
`ifdef ARB_LOCK_EN
        lockCnt_d  = lockCnt_q;
        lockHold   = (|(lock & gnt_q)) && (lockCnt_q < LockLast);
`endif

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = idleWinner;
                    sel_d   = oneHotToSel(idleWinner);
                end
            end
            GRANT: begin
                if (accept && lockHold) begin
`ifdef ARB_LOCK_EN
                    lockCnt_d = lockCnt_q + 4'd1;
`endif
                end else if (accept) begin
                    ptr_d = nextPtr(sel_q);
`ifdef ARB_LOCK_EN
                    lockCnt_d = 4'd0;
`endif
                    if (|maskedReq) begin
                        gnt_d = rotWinner;
                        sel_d = oneHotToSel(rotWinner);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 3'b000;
                    end
                end else if (!grantedReq) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
`ifdef ARB_LOCK_EN
                    lockCnt_d = 4'd0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // State register. sel is left untouched on the way to IDLE so the mux
    // keeps pointing at the last grantee.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            sel_q   <= SEL_IN00;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_LOCK_EN
    // Lock beat counter, cleared on reset, grant change and withdrawal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockCnt_q <= 4'd0;
        end else begin
            lockCnt_q <= lockCnt_d;
        end
    end
`endif

endmodule

// File: doc/mux3_arbiter.md
# mux3_arbiter

Round-robin arbiter sharing the 32-bit 3:1 datapath mux between three requesters. Grants one requester at a time, drives the mux select, and presents the selected word to a single consumer with a valid/ready handshake. It sits in front of the shared write-back/result bus, where three producers compete for one destination.

## Interface
Parameters:
- WIDTH, 32, data width of each input and of out_data
- MAX_LOCK, 8, maximum consecutive beats one requester may hold under lock (ARB_LOCK_EN only); legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  3  request per requester; bit i high = requester i holds a valid word
- in00 / in01 / in10  in  WIDTH each  data of requesters 0 / 1 / 2
- lock  in  3  per-requester hold-grant flag (present only with ARB_LOCK_EN)
- out_ready  in  1  consumer accepts out_data this cycle
- out_valid  out  1  out_data is valid
- out_data  out  WIDTH  selected word
- sel  out  2  mux select: 2'b00 → in00, 2'b01 → in01, 2'b10 → in10; 2'b11 is never driven
- gnt  out  3  one-hot registered grant; 3'b000 when idle
- ack  out  3  one-hot; bit i pulses in the cycle requester i's word is accepted

## Operation
- FSM states:
  - IDLE: gnt = 000.
  - GRANT: exactly one gnt bit set.
- Priority pointer ptr (0..2), reset 0. The winner is the first requesting index at or after ptr, searching ptr, ptr+1, ptr+2 mod 3.
- IDLE → GRANT when any req bit is high. gnt and sel are registered from the winner.
- In GRANT:
  - out_valid = req[g]
  - out_data = mux output for sel
  - ack[g] = out_valid & out_ready, combinational
- Accept (ack[g] = 1):
  - ptr ← g+1 mod 3.
  - Re-arbitrate in the same edge with req[g] masked, so the current grantee cannot win twice in a row.
  - If another request wins, stay in GRANT with the new grantee (no bubble). Otherwise go to IDLE.
- Withdrawal: if req[g] drops before accept, return to IDLE next edge. ptr is unchanged and no ack is issued.
- Requester obligations:
  - Hold its data stable while req is high and ack is low.
  - Keep req high after ack if it has another word; that word is treated as a new request.
- Outputs in IDLE: sel holds the last grantee's value; out_data follows the mux on that sel but is don't-care; out_valid = 0.
- Reset value of every output: gnt = 000, sel = 2'b00, ack = 000, out_valid = 0, out_data = in00. Internally ptr = 0 and the lock count is cleared.
- Reset asserted mid-transfer clears state immediately with no ack. The consumer must discard any word not yet acked.

## Timing
- req rising at edge N → gnt/sel valid after edge N+1 → earliest ack in cycle N+1. Arbitration latency is 1 cycle.
- Back-to-back grants to different requesters: 1 beat per cycle, no idle cycle.
- A lone requester streaming words: 1 beat every 2 cycles because of masking (GRANT, IDLE, GRANT...). Under ARB_LOCK_EN with lock held, it streams at 1 beat per cycle.
- ack is a same-cycle combinational function of out_ready; there is no registered path from out_ready to ack.

## Configuration
- Macro: ARB_LOCK_EN.
- Defined:
  - The lock port exists.
  - On accept with lock[g] = 1 and beat count < MAX_LOCK, the grant is retained: no mask, ptr not advanced, count+1.
  - When the count reaches MAX_LOCK, lock is ignored for that accept, normal rotation applies, and the count clears.
  - The count also clears on any grant change or on withdrawal.
- Not defined: no lock port and no counter; strict one-beat-per-grant rotation.

## Structure
- Shared package mux3_arb_pkg holds:
  - FSM state encoding (IDLE, GRANT)
  - SEL_IN00 / SEL_IN01 / SEL_IN10 constants
  - The one-hot-to-sel mapping function
- One sub-module: the existing Mux_3_1, instantiated as the datapath.
- The arbiter itself is a single flat module.

## Test plan
- Reset: rst_n = 0 with req = 111 → gnt = 000, sel = 00, out_valid = 0, ack = 000. Release → grant to requester 0 one cycle later.
- Single request: req = 010, in01 = 14, out_ready = 1 → next cycle gnt = 010, sel = 01, out_data = 14, ack = 010. Following cycle gnt = 000.
- Full contention: req = 111, in00/in01/in10 = 3/14/24, out_ready = 1 → gnt sequence 001, 010, 100, 001; out_data 3, 14, 24, 3; one ack per cycle.
- Backpressure: req = 100, out_ready = 0 for 5 cycles → gnt = 100 and out_data = 24 stable, ack = 000. out_ready = 1 → ack = 100 that cycle.
- Withdrawal and reset:
  - req[1] drops while granted → IDLE next cycle, ptr unchanged, no ack.
  - rst_n pulsed low mid-grant → outputs clear asynchronously.
- Lock (ARB_LOCK_EN, MAX_LOCK = 4): req = 011, lock = 001, out_ready = 1 → 4 consecutive acks to requester 0, then grant 010.
